activity_monitor: RTL and testbench



---
 rtl/activity_monitor.sv | 134 +++++++++++++
 tb/tb_activity_monitor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/activity_monitor.sv
// activity_monitor
//   Multi-channel activity detector for status LEDs (SD/VHD, tape, UART, ...).
//   Each channel watches a bundle of WIDTH signals. A channel is active while any
//   of its bits toggled within the last TIMEOUT cycles. All channels are merged
//   into one LED output, which is either steady or blinking. Each channel also
//   has a one-cycle pulse on the rising edge of its activity flag.
//
//   Ports
//     clk_sys   in   1               system clock, rising edge
//     reset     in   1               synchronous, active-high
//     en        in   CHANNELS        per-channel enable
//     sig       in   CHANNELS*WIDTH  watched signals, channel i = sig[i*WIDTH +: WIDTH]
//     act       out  CHANNELS        per-channel activity
//     act_rise  out  CHANNELS        one-cycle pulse on act 0->1
//     act_any   out  1               OR of all act bits
//     led       out  1               LED drive (steady or blinking)
//
//   Handshake: none. Every input is sampled on each rising clk_sys edge, and all
//   outputs are decoded from registers only. No combinational path runs from an
//   input to an output.
module activity_monitor #(
  parameter int CHANNELS     = 2,
  parameter int WIDTH        = 2,
  parameter int TIMEOUT      = 2000000,
  parameter int START_ACTIVE = 1,
  parameter int BLINK_HALF   = 0
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] sig,
  output logic [CHANNELS-1:0]       act,
  output logic [CHANNELS-1:0]       act_rise,
  output logic                      act_any,
  output logic                      led
);

  // Illegal parameterisations are rejected at elaboration.
  if (CHANNELS < 1) begin : g_bad_channels
    $error("activity_monitor: CHANNELS must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("activity_monitor: WIDTH must be >= 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("activity_monitor: TIMEOUT must be >= 1");
  end

  localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX    = CW'(TIMEOUT);
  localparam logic          SA      = (START_ACTIVE != 0);
  // START_ACTIVE loads a fresh window on reset. Otherwise the counter starts expired.
  localparam logic [CW-1:0] CNT_RST = SA ? '0 : TMAX;

  // ---------------------------------------------------------------------------
  // Per-channel toggle detection and timeout counter
  // ---------------------------------------------------------------------------
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    cnt;
    logic             toggle;

    assign cur    = sig[ch*WIDTH +: WIDTH];
    assign toggle = en[ch] & (|(cur ^ prev));

    // prev tracks sig every cycle, even while disabled. When en rises again,
    // prev already matches sig, so no stale difference can look like a toggle.
    always_ff @(posedge clk_sys) begin
      prev <= cur;
      if (reset) begin
        cnt <= CNT_RST;
      end else if (!en[ch]) begin
        cnt <= TMAX;
      end else if (toggle) begin
        cnt <= '0;
      end else if (cnt < TMAX) begin
        cnt <= cnt + 1'b1;
      end
    end

    // The counter saturates at TMAX, so act is high for exactly TIMEOUT cycles
    // after the last toggle.
    assign act[ch] = (cnt < TMAX);
  end

  // ---------------------------------------------------------------------------
  // Rising-edge pulse
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] act_d;

  // act_d is reset to the same value act takes after reset. No pulse can appear
  // on the first cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      act_d <= {CHANNELS{SA}};
    end else begin
      act_d <= act;
    end
  end

  assign act_rise = act & ~act_d;
  assign act_any  = |act;

  // ---------------------------------------------------------------------------
  // LED drive
  // ---------------------------------------------------------------------------
  if (BLINK_HALF > 0) begin : g_blink
    localparam int            BW    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLAST = BW'(BLINK_HALF - 1);

    logic [BW-1:0] bcnt;
    logic          phase;

    // The blink phase clears whenever nothing is active. Every new burst, even
    // after a single idle cycle, starts with the LED on.
    always_ff @(posedge clk_sys) begin
      if (reset || !act_any) begin
        bcnt  <= '0;
        phase <= 1'b0;
      end else if (bcnt == BLAST) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt  <= bcnt + 1'b1;
      end
    end

    assign led = act_any & ~phase;
  end else begin : g_steady
    assign led = act_any;
  end

endmodule

// File: tb/tb_activity_monitor.sv
// tb_activity_monitor
//   Directed bench for activity_monitor. It uses three instances:
//     dut_a: START_ACTIVE=1, TIMEOUT=8, steady LED
//     dut_b: START_ACTIVE=0, TIMEOUT=8, steady LED
//     dut_c: START_ACTIVE=0, TIMEOUT=20, BLINK_HALF=3
//   Inputs change #1 after a rising edge, and outputs are checked at that time.
//   Label k in the comments means the value seen at edge n+k, where edge n
//   sampled the toggle.
module tb_activity_monitor;

  logic       clk_sys;
  logic       rst_a, rst_b, rst_c;
  logic [1:0] en_a, en_b, en_c;
  logic [3:0] sig_a, sig_b, sig_c;
  logic [1:0] act_a, act_b, act_c;
  logic [1:0] rise_a, rise_b, rise_c;
  logic       any_a, any_b, any_c;
  logic       led_a, led_b, led_c;

  int checks   = 0;
  int failures = 0;

  activity_monitor #(
    .CHANNELS(2), .WIDTH(2), .TIMEOUT(8), .START_ACTIVE(1), .BLINK_HALF(0)
  ) dut_a (
    .clk_sys(clk_sys), .reset(rst_a), .en(en_a), .sig(sig_a),
    .act(act_a), .act_rise(rise_a), .act_any(any_a), .led(led_a)
  );

  activity_monitor #(
    .CHANNELS(2), .WIDTH(2), .TIMEOUT(8), .START_ACTIVE(0), .BLINK_HALF(0)
  ) dut_b (
    .clk_sys(clk_sys), .reset(rst_b), .en(en_b), .sig(sig_b),
    .act(act_b), .act_rise(rise_b), .act_any(any_b), .led(led_b)
  );

  activity_monitor #(
    .CHANNELS(2), .WIDTH(2), .TIMEOUT(20), .START_ACTIVE(0), .BLINK_HALF(3)
  ) dut_c (
    .clk_sys(clk_sys), .reset(rst_c), .en(en_c), .sig(sig_c),
    .act(act_c), .act_rise(rise_c), .act_any(any_c), .led(led_c)
  );

  // Clock / reset block
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [19:0] exp_led;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    en_a  = 2'b11; en_b = 2'b11; en_c = 2'b11;
    sig_a = 4'b0000; sig_b = 4'b0000; sig_c = 4'b0000;
    step();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Reset values
    chk("b_reset_act",  32'(act_b),  32'h0);
    chk("b_reset_rise", 32'(rise_b), 32'h0);
    chk("b_reset_led",  32'(led_b),  32'h0);
    chk("c_reset_led",  32'(led_c),  32'h0);

    // 1. START_ACTIVE=1: 8 active cycles after reset, then idle, no pulse
    for (int i = 0; i < 8; i++) begin
      chk("a_start_act",  32'(act_a),  32'h3);
      chk("a_start_rise", 32'(rise_a), 32'h0);
      chk("a_start_led",  32'(led_a),  32'h1);
      step();
    end
    chk("a_start_end_act",  32'(act_a),  32'h0);
    chk("a_start_end_any",  32'(any_a),  32'h0);
    chk("a_start_end_led",  32'(led_a),  32'h0);
    chk("a_start_end_rise", 32'(rise_a), 32'h0);

    // 2. Single toggle on ch0: labels 1..8 active, label 9 idle
    sig_b = sig_b ^ 4'b0001;
    step();
    chk("b_t2_act_l1",  32'(act_b),  32'h1);
    chk("b_t2_rise_l1", 32'(rise_b), 32'h1);
    for (int l = 2; l <= 8; l++) begin
      step();
      chk("b_t2_act",  32'(act_b),  32'h1);
      chk("b_t2_rise", 32'(rise_b), 32'h0);
    end
    step();
    chk("b_t2_act_l9", 32'(act_b), 32'h0);
    chk("b_t2_any_l9", 32'(any_b), 32'h0);

    // 3. ch1 toggles at edges n and n+5: active labels 1..13, one pulse
    sig_b = sig_b ^ 4'b0100;
    step();
    chk("b_t3_act_l1",  32'(act_b),  32'h2);
    chk("b_t3_rise_l1", 32'(rise_b), 32'h2);
    for (int l = 2; l <= 13; l++) begin
      if (l == 6) sig_b = sig_b ^ 4'b0100;
      step();
      chk("b_t3_act",  32'(act_b),  32'h2);
      chk("b_t3_rise", 32'(rise_b), 32'h0);
    end
    step();
    chk("b_t3_act_l14", 32'(act_b), 32'h0);

    // 4. Enable gating
    sig_b = sig_b ^ 4'b0001;
    step();
    chk("b_t4_act_on",  32'(act_b),  32'h1);
    chk("b_t4_rise_on", 32'(rise_b), 32'h1);
    step();
    chk("b_t4_act_on2", 32'(act_b), 32'h1);
    en_b = 2'b10;
    step();
    chk("b_t4_en_drop", 32'(act_b), 32'h0);
    sig_b = sig_b ^ 4'b0001;
    step();
    chk("b_t4_dis_toggle", 32'(act_b), 32'h0);
    step();
    chk("b_t4_dis_toggle2", 32'(act_b), 32'h0);
    en_b = 2'b11;
    step();
    chk("b_t4_en_rise_act",  32'(act_b),  32'h0);
    chk("b_t4_en_rise_rise", 32'(rise_b), 32'h0);
    step();
    chk("b_t4_en_rise_act2", 32'(act_b), 32'h0);

    // 6. Reset mid-window (cnt=4 at label 5)
    sig_b = sig_b ^ 4'b0001;
    step();
    chk("b_t6_act_l1", 32'(act_b), 32'h1);
    for (int l = 2; l <= 5; l++) begin
      step();
      chk("b_t6_act_pre", 32'(act_b), 32'h1);
    end
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    chk("b_t6_rst_act",  32'(act_b),  32'h0);
    chk("b_t6_rst_rise", 32'(rise_b), 32'h0);
    chk("b_t6_rst_led",  32'(led_b),  32'h0);
    step();
    chk("b_t6_post_act",  32'(act_b),  32'h0);
    chk("b_t6_post_rise", 32'(rise_b), 32'h0);
    sig_b = sig_b ^ 4'b0100;
    step();
    chk("b_t6_resume_act",  32'(act_b),  32'h2);
    chk("b_t6_resume_rise", 32'(rise_b), 32'h2);

    // 5. Blink, 3 on / 3 off over a 20-cycle window (bit k-1 = label k)
    exp_led = 20'b11_000_111_000_111_000_111;
    sig_c = sig_c ^ 4'b0001;
    step();
    chk("c_t5_rise_l1", 32'(rise_c), 32'h1);
    for (int l = 1; l <= 20; l++) begin
      chk("c_t5_led", 32'(led_c),  32'(exp_led[l-1]));
      chk("c_t5_any", 32'(any_c),  32'h1);
      step();
    end
    chk("c_t5_end_any", 32'(any_c), 32'h0);
    chk("c_t5_end_led", 32'(led_c), 32'h0);
    // New burst after one idle cycle starts with the LED on.
    sig_c = sig_c ^ 4'b0100;
    step();
    for (int l = 1; l <= 4; l++) begin
      chk("c_t5_burst2_led", 32'(led_c), 32'(exp_led[l-1]));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
